fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Generates word-aligned fetch addresses, issues in-order requests to instruction memory, buffers returned 32-bit words in a small queue, and presents them with their PC to the decoder over a valid/ready handshake. Handles control-flow redirects by flushing the queue and discarding in-flight responses.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default `4`: queue entries and maximum outstanding requests; power of two, ≥ 2.

**Ports**
- Clock and reset: one clock; reset is synchronous and active-high.
  - `i_clk`  in  1: clock.
  - `i_rst`  in  1: synchronous, active-high reset.
- Instruction memory request channel:
  - `o_imem_req_valid`  out  1: request valid.
  - `i_imem_req_ready`  in  1: memory accepts the request.
  - `o_imem_req_addr`  out  32: word address; [1:0] always 0.
- Instruction memory response channel:
  - `i_imem_rsp_valid`  in  1: response valid; in order; never in the cycle that request is accepted.
  - `i_imem_rsp_data`  in  32: instruction word.
- Redirect:
  - `i_redirect_valid`  in  1: redirect request.
  - `i_redirect_pc`  in  32: new PC; bits [1:0] ignored (treated as 0).
- Decoder side:
  - `o_inst_valid`  out  1: instruction available.
  - `i_inst_ready`  in  1: decoder consumes it.
  - `o_inst`  out  32: instruction word.
  - `o_inst_pc`  out  32: PC of `o_inst`.

## Operation

**State:**
- `fetch_pc`: next address to request.
- Queue of {pc, inst}, `DEPTH` entries, with `count`.
- `outstanding`: accepted requests not yet responded.
- `discard`: responses still to be dropped.
- Per-request PC FIFO, or equivalently `resp_pc`: the PC of the next expected response.

**Request rule:**
- `o_imem_req_valid` = !i_rst_q && (count + outstanding < DEPTH). It is purely registered-state driven, independent of redirect.
- On accept: `fetch_pc += 4` (wraps modulo 2^32), `outstanding += 1`.

**Response handling:**
- If `discard > 0`: the response is dropped and `discard -= 1`.
- Otherwise it is written to the queue tail with `resp_pc`, and `resp_pc += 4`.
- In both cases `outstanding -= 1`.
- Overflow is impossible by the credit rule. A response arriving with `outstanding == 0` is a protocol error; the bench asserts it never happens.

**Decoder output:**
- `o_inst_valid` = count != 0.
- `o_inst`/`o_inst_pc` come from the queue head.
- Pop when valid && ready.

**Redirect (highest priority):**
- Queue cleared (count = 0; a pop in the same cycle is ignored).
- `fetch_pc` = `resp_pc` = {i_redirect_pc[31:2], 2'b00}.
- `discard` = outstanding + (request accepted this cycle) − (response arriving this cycle).
- A response arriving in the redirect cycle is dropped.
- A request accepted in the redirect cycle used the old PC and is discarded later.

**Simultaneous events:**
- Push and pop in the same cycle: count unchanged.
- Accept and response in the same cycle: outstanding unchanged.

**Reset mid-operation:** all counters are cleared. Responses to pre-reset requests are a system error; the memory must be reset together with this block.

## Timing

- **Reset values:** `o_imem_req_valid` 0, `o_imem_req_addr` RESET_PC, `o_inst_valid` 0, `o_inst` 0, `o_inst_pc` 0; count, outstanding and discard 0.
- **First request:** `o_imem_req_valid` rises in the first cycle after `i_rst` deasserts, with addr RESET_PC.
- **Latency:** request accepted in cycle t, response in cycle t+k (k ≥ 1), `o_inst_valid` in cycle t+k+1. There is no response-to-output bypass.
- **Redirect:** redirect in cycle r puts the new PC on `o_imem_req_addr` in cycle r+1, and `o_inst_valid` is 0 in cycle r+1.
- **Throughput:** one instruction per cycle sustained when k < DEPTH and the decoder is always ready.
- **Handshake:** `o_imem_req_addr` is stable while valid && !ready, unless a redirect occurs, in which case the address changes next cycle. The memory must tolerate this; it is documented as allowed.

## Structure

- **Shared header:** `RESET_PC` default, instruction width (32), and the word-align mask. These are shared with the decoder and the later execute stage.
- **Sub-module `fetch_queue`:** synchronous FIFO with `DEPTH` entries of 64 bits ({pc, inst}).
  - Ports: push, pop, flush, count, head data.
  - Pointers wrap via log2(DEPTH) bits.
  - Count needs log2(DEPTH)+1 bits.
- `fetch_unit` holds the PC, the credit counters, the discard logic, and the redirect priority.

## Test plan

- **Reset and stream:** release reset, memory with k=1, always ready → addresses 0,4,8,…; first `o_inst_valid` 3 cycles after reset release; then one instruction per cycle with `o_inst_pc` matching.
- **Backpressure:** `i_inst_ready`=0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, then `o_imem_req_valid` 0; on release, 4 instructions drain in order and fetch resumes at 0x10.
- **Redirect with in-flight:**
  - Setup: k=3, 2 outstanding plus 1 accepted in the redirect cycle; redirect to 0x1003.
  - Response: the next 3 responses are dropped; the first output is at pc 0x1000.
- **Redirect on response/pop cycle:** a redirect coinciding with a response and a pop leaves the queue empty next cycle and the response is discarded (no stale pc appears).
- **Wrap-around:** RESET_PC=0xFFFF_FFF8 → pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- **Reset mid-stream:** `i_rst` asserted with a full queue → next cycle `o_inst_valid`=0 and `o_imem_req_valid`=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Definitions shared by the fetch stage, the decoder and the execute stage:
//   instruction/address widths, the default reset PC, the word-align mask and
//   the {pc, inst} record carried through the fetch queue.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [ADDR_W-1:0] WORD_BYTES       = 32'd4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles every non-clock signal of the fetch stage:
//     imem request   : o_imem_req_valid / i_imem_req_ready / o_imem_req_addr
//     imem response  : i_imem_rsp_valid / i_imem_rsp_data (in order)
//     redirect       : i_redirect_valid / i_redirect_pc
//     decoder output : o_inst_valid / i_inst_ready / o_inst / o_inst_pc
//   The o_/i_ prefixes are seen from the fetch unit; it uses the master
//   modport, while the memory/decoder/branch environment uses slave.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              o_imem_req_valid;
  logic              i_imem_req_ready;
  logic [ADDR_W-1:0] o_imem_req_addr;

  logic              i_imem_rsp_valid;
  logic [INST_W-1:0] i_imem_rsp_data;

  logic              i_redirect_valid;
  logic [ADDR_W-1:0] i_redirect_pc;

  logic              o_inst_valid;
  logic              i_inst_ready;
  logic [INST_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_pc;

  modport master (
    output o_imem_req_valid, o_imem_req_addr,
    input  i_imem_req_ready,
    input  i_imem_rsp_valid, i_imem_rsp_data,
    input  i_redirect_valid, i_redirect_pc,
    output o_inst_valid, o_inst, o_inst_pc,
    input  i_inst_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_req_addr,
    output i_imem_req_ready,
    output i_imem_rsp_valid, i_imem_rsp_data,
    output i_redirect_valid, i_redirect_pc,
    input  o_inst_valid, o_inst, o_inst_pc,
    output i_inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Synchronous FIFO of DEPTH {pc, inst} entries between the imem response
//   and the decoder.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     push         : write push_data at the tail (ignored when full)
//     pop          : drop the head entry (ignored when empty)
//     flush        : synchronous clear, wins over push and pop
//     count        : number of valid entries, 0..DEPTH
//     head         : entry at the head (only meaningful when count != 0)
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned     PW   = $clog2(DEPTH);
  localparam logic [PW:0]     FULL = (PW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);

  // DEPTH is a power of two, so the pointers wrap on their natural overflow.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately left without a reset; an entry is
  // never read before it is written because count gates every consumer.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of the decoder. Issues in-order,
//   word-aligned requests to instruction memory, buffers returned words in a
//   DEPTH-entry queue and hands {inst, pc} to the decoder. A redirect flushes
//   the queue and discards every response still in flight.
//   Parameters:
//     RESET_PC : first fetch address after reset (bits [1:0] must be 0)
//     DEPTH    : queue entries = maximum requests in flight (power of 2, >= 2)
//   Ports:
//     i_clk    : clock
//     i_rst    : synchronous, active-high reset
//     bus      : fetch_unit_if.master (imem request/response, redirect,
//                decoder handshake)
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       DEPTH    = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;         // next address to request
  logic [ADDR_W-1:0] resp_pc;          // PC of the next response to keep
  logic [ADDR_W-1:0] redirect_target;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;      // accepted, not yet answered
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     discard;          // responses still to be dropped
  logic              rst_q;            // first cycle out of reset: no request yet
  logic              req_valid;
  logic              req_fire;
  logic              rsp_fire;
  logic              redirect;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    bus.o_inst    = '0;
    bus.o_inst_pc = '0;
    if (count != '0) begin
      bus.o_inst    = head.inst;
      bus.o_inst_pc = head.pc;
    end

    // A slot stays reserved from request acceptance until the decoder pops
    // the word, so the queue can never overflow.
    req_valid = !rst_q && (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    req_fire  = req_valid && bus.i_imem_req_ready;
    rsp_fire  = bus.i_imem_rsp_valid;
    redirect  = bus.i_redirect_valid;
    redirect_target = word_align(bus.i_redirect_pc);

    // Redirect has priority: a response in that cycle is dropped and a pop
    // is ignored because the queue is being flushed anyway.
    push = rsp_fire && (discard == '0) && !redirect;
    pop  = (count != '0) && bus.i_inst_ready && !redirect;
    push_entry = '{pc: resp_pc, inst: bus.i_imem_rsp_data};

    outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
  end

  assign bus.o_imem_req_valid = req_valid;
  assign bus.o_imem_req_addr  = fetch_pc;
  assign bus.o_inst_valid     = (count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_q       <= 1'b1;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      rst_q       <= 1'b0;
      outstanding <= outstanding_next;
      if (redirect) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        // Everything still in flight after this edge, including a request
        // accepted right now with the old PC, belongs to the old stream.
        discard  <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + WORD_BYTES;
        if (push)     resp_pc  <= resp_pc + WORD_BYTES;
        if (rsp_fire && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit (RESET_PC = 0) as instruction memory, decoder and branch
//   unit, and compares every cycle against a queue-based reference model.
//   A second instance with RESET_PC = 0xFFFF_FFF8 covers address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] RPC     = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bus)
  );
  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .i_clk (clk), .i_rst (rst2), .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  req_t        m_inflight[$];   // requests sent, oldest first
  ent_t        m_q[$];          // instructions waiting for the decoder
  logic [31:0] m_fetch_pc;
  bit          m_rst_q;
  bit          model_valid = 0;

  pend_t       mem_pend[$];     // memory side: accepted requests awaiting reply

  // ---------------- stimulus knobs and observations ----------------
  int          req_ready_pct  = 100;
  int          inst_ready_pct = 100;
  int          redir_pct      = 0;
  int          k_min          = 1;
  int          k_max          = 1;
  bit          rst_drive      = 1;
  bit          redir_once     = 0;
  logic [31:0] redir_once_pc  = '0;

  bit          s_req_valid, s_inst_valid, s_rsp, s_accept;
  logic [31:0] s_req_addr, s_inst_pc, s_inst;

  // One clock cycle: sample/compare mid-cycle, drive inputs, advance model.
  task automatic step();
    bit          e_rv, e_iv, acc, pop, rsp, redir;
    logic [31:0] rpc;
    req_t        tag;
    pend_t       p;
    @(negedge clk);
    cyc++;
    s_req_valid  = bus.o_imem_req_valid;
    s_req_addr   = bus.o_imem_req_addr;
    s_inst_valid = bus.o_inst_valid;
    s_inst_pc    = bus.o_inst_pc;
    s_inst       = bus.o_inst;

    e_rv = !m_rst_q && ((m_q.size() + m_inflight.size()) < DEPTH);
    e_iv = (m_q.size() != 0);
    if (model_valid) begin
      check("req_valid", 32'(s_req_valid), 32'(e_rv));
      check("req_addr", s_req_addr, m_fetch_pc);
      check("inst_valid", 32'(s_inst_valid), 32'(e_iv));
      if (e_iv) begin
        check("inst_pc", s_inst_pc, m_q[0].pc);
        check("inst", s_inst, m_q[0].inst);
      end
    end

    redir = redir_once || ($urandom_range(0, 99) < redir_pct);
    rpc   = redir_once ? redir_once_pc : $urandom();
    redir_once = 0;
    rst = rst_drive;
    bus.i_imem_req_ready = ($urandom_range(0, 99) < req_ready_pct);
    bus.i_inst_ready     = ($urandom_range(0, 99) < inst_ready_pct);
    bus.i_redirect_valid = redir;
    bus.i_redirect_pc    = rpc;

    rsp = 0;
    if (rst_drive) begin
      mem_pend.delete();
    end else if (mem_pend.size() != 0 && mem_pend[0].due <= cyc) begin
      p   = mem_pend.pop_front();
      rsp = 1;
    end
    bus.i_imem_rsp_valid = rsp;
    bus.i_imem_rsp_data  = rsp ? mem_word(p.addr) : $urandom();
    s_rsp    = rsp;
    s_accept = !rst_drive && s_req_valid && bus.i_imem_req_ready;
    if (s_accept) mem_pend.push_back('{addr: s_req_addr, due: cyc + $urandom_range(k_min, k_max)});

    if (rst_drive) begin
      m_q.delete();
      m_inflight.delete();
      m_fetch_pc  = RPC;
      m_rst_q     = 1;
      model_valid = 1;
    end else if (model_valid) begin
      acc = e_rv && bus.i_imem_req_ready;
      pop = e_iv && bus.i_inst_ready;
      tag = '{pc: '0, stale: 1'b1};
      if (rsp) begin
        check("rsp_has_outstanding", 32'(m_inflight.size() != 0), 32'd1);
        if (m_inflight.size() != 0) tag = m_inflight.pop_front();
      end
      if (redir) begin
        m_q.delete();
        foreach (m_inflight[i]) m_inflight[i].stale = 1;
        if (acc) m_inflight.push_back('{pc: m_fetch_pc, stale: 1'b1});
        m_fetch_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (rsp && !tag.stale) m_q.push_back('{pc: tag.pc, inst: mem_word(tag.pc)});
        if (acc) begin
          m_inflight.push_back('{pc: m_fetch_pc, stale: 1'b0});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
      m_rst_q = 0;
    end
  endtask

  task automatic do_reset();
    rst_drive = 1;
    repeat (2) step();
    rst_drive = 0;
  endtask

  // Second instance: reset at 0xFFFF_FFF8, k = 1, decoder always ready.
  task automatic wrap_test();
    logic [31:0] exp_pc[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    logic [31:0] pend[$];
    int got = 0;
    bus2.i_imem_req_ready = 1; bus2.i_inst_ready = 1;
    bus2.i_redirect_valid = 0; bus2.i_redirect_pc = '0;
    bus2.i_imem_rsp_valid = 0; bus2.i_imem_rsp_data = '0;
    rst2 = 1;
    repeat (2) @(negedge clk);
    rst2 = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      @(negedge clk);
      if (bus2.o_inst_valid) begin
        check($sformatf("wrap_pc%0d", got), bus2.o_inst_pc, exp_pc[got]);
        check($sformatf("wrap_inst%0d", got), bus2.o_inst, mem_word(exp_pc[got]));
        got++;
      end
      bus2.i_imem_rsp_valid = (pend.size() != 0);
      bus2.i_imem_rsp_data  = (pend.size() != 0) ? mem_word(pend.pop_front()) : '0;
      if (bus2.o_imem_req_valid) pend.push_back(bus2.o_imem_req_addr);
    end
    check("wrap_count", 32'(got), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, first_req, first_val, n_acc, got, n_rsp;
    bit found;
    rst = 1; rst2 = 1;
    bus.i_imem_req_ready = 0; bus.i_imem_rsp_valid = 0; bus.i_imem_rsp_data = '0;
    bus.i_redirect_valid = 0; bus.i_redirect_pc = '0; bus.i_inst_ready = 0;

    // ---- reset values and streaming, k = 1 ----
    do_reset();
    step();
    rel = cyc;
    check("rst_req_valid", 32'(s_req_valid), 32'd0);
    check("rst_req_addr", s_req_addr, RPC);
    check("rst_inst_valid", 32'(s_inst_valid), 32'd0);
    check("rst_inst", s_inst, 32'd0);
    check("rst_inst_pc", s_inst_pc, 32'd0);
    first_req = -1; first_val = -1;
    for (int i = 0; i < 10 && first_val < 0; i++) begin
      step();
      if (s_req_valid && first_req < 0) begin
        first_req = cyc;
        check("first_req_addr", s_req_addr, RPC);
      end
      if (s_inst_valid) first_val = cyc;
    end
    check("first_req_latency", 32'(first_req - rel), 32'd1);
    check("first_valid_latency", 32'(first_val - rel), 32'd3);
    check("stream_pc0", s_inst_pc, 32'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      check("stream_valid", 32'(s_inst_valid), 32'd1);
      check($sformatf("stream_pc%0d", i), s_inst_pc, 32'(4 * i));
    end

    // ---- backpressure ----
    do_reset();
    inst_ready_pct = 0;
    step();
    n_acc = 0;
    repeat (10) begin
      step();
      n_acc += int'(s_accept);
    end
    check("bp_accepts", 32'(n_acc), 32'd4);
    check("bp_req_valid_low", 32'(s_req_valid), 32'd0);
    inst_ready_pct = 100;
    got = 0; found = 0;
    for (int i = 0; i < 20 && (got < 4 || !found); i++) begin
      step();
      if (s_inst_valid && got < 4) begin
        check($sformatf("bp_drain_pc%0d", got), s_inst_pc, 32'(4 * got));
        got++;
      end
      if (s_accept && !found) begin
        found = 1;
        check("bp_resume_addr", s_req_addr, 32'h10);
      end
    end
    check("bp_drained", 32'(got), 32'd4);
    check("bp_resumed", 32'(found), 32'd1);

    // ---- redirect with 2 in flight + 1 accepted in the redirect cycle, k = 3 ----
    do_reset();
    k_min = 3; k_max = 3;
    repeat (3) step();
    redir_once = 1; redir_once_pc = 32'h1003;
    step();
    check("redir_cycle_accept", 32'(s_accept), 32'd1);
    step();
    check("redir_next_addr", s_req_addr, 32'h1000);
    check("redir_next_inst_valid", 32'(s_inst_valid), 32'd0);
    n_rsp = int'(s_rsp); found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (s_inst_valid) found = 1;
      else n_rsp += int'(s_rsp);
    end
    check("redir_first_pc", s_inst_pc, 32'h1000);
    check("redir_dropped", 32'(n_rsp - 1), 32'd3);
    k_min = 1; k_max = 1;

    // ---- redirect coinciding with a response and a pop ----
    do_reset();
    repeat (7) step();
    redir_once = 1; redir_once_pc = 32'h2000;
    step();
    check("coincide_rsp", 32'(s_rsp), 32'd1);
    check("coincide_pop", 32'(s_inst_valid), 32'd1);
    step();
    check("coincide_next_inst_valid", 32'(s_inst_valid), 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = s_inst_valid;
    end
    check("coincide_first_pc", s_inst_pc, 32'h2000);

    // ---- reset with a full queue ----
    do_reset();
    inst_ready_pct = 0;
    repeat (13) step();
    check("full_inst_valid", 32'(s_inst_valid), 32'd1);
    rst_drive = 1;
    step();
    rst_drive = 0;
    step();
    check("midrst_inst_valid", 32'(s_inst_valid), 32'd0);
    check("midrst_req_valid", 32'(s_req_valid), 32'd0);
    step();
    check("midrst_restart_valid", 32'(s_req_valid), 32'd1);
    check("midrst_restart_addr", s_req_addr, RPC);
    inst_ready_pct = 100;

    // ---- randomized traffic ----
    req_ready_pct = 70; inst_ready_pct = 65; redir_pct = 4; k_min = 1; k_max = 5;
    for (int i = 0; i < 3000; i++) begin
      rst_drive = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_drive = 0; redir_pct = 0;

    // ---- address wrap on the second instance ----
    wrap_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
